add_round_seq: RTL and testbench

ADD_ROUND_SEQ -- requirements
Module: add_round_seq

---
 rtl/add_round_seq.sv | 159 +++++++++++++++
 tb/tb_add_round_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/add_round_seq.sv
// Keyed-state sequencer: whitens a plaintext block, then XORs each fed-back round
// result with the round key. Define ADD_ROUND_PARITY_EN for per-byte even parity on state_par_o.
module add_round_seq #(
  parameter int DATA_W = 64,
  parameter int ROUNDS = 25,
  parameter int CNT_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     plain_in,
  input  logic [DATA_W-1:0]     key_round,
  input  logic [DATA_W-1:0]     fb_state,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     state_o,
  output logic [CNT_W-1:0]      round_o,
  output logic                  last_o,
  output logic [DATA_W/8-1:0]   state_par_o
);

  localparam int              PAR_W      = DATA_W / 8;
  localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(ROUNDS);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } fsm_t;

  fsm_t              fsm_q, fsm_d;
  logic [DATA_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]  round_q, round_d;
  logic              out_valid_q, out_valid_d;
  logic              in_fire_s;
  logic              out_fire_s;
  logic              at_last_s;

  // in_ready drops while reset is asserted, not one cycle after it
  assign in_ready   = rst && (fsm_q == S_IDLE);
  assign in_fire_s  = in_valid && in_ready;
  assign out_fire_s = out_valid_q && out_ready;
  assign at_last_s  = (round_q == LAST_ROUND);

  assign out_valid  = out_valid_q;
  assign state_o    = state_q;
  assign round_o    = round_q;
  assign last_o     = out_valid_q && at_last_s;

  // State register for FSM and datapath
  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm_q       <= S_IDLE;
      state_q     <= {DATA_W{1'b0}};
      round_q     <= {CNT_W{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      round_q     <= round_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    fsm_d = fsm_q;
    if (flush) begin
      fsm_d = S_IDLE;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          if (in_fire_s) begin
            fsm_d = S_RUN;
          end else begin
            fsm_d = S_IDLE;
          end
        end
        S_RUN: begin
          if (out_fire_s && at_last_s) begin
            fsm_d = S_IDLE;
          end else begin
            fsm_d = S_RUN;
          end
        end
        default: fsm_d = S_IDLE;
      endcase
    end
  end

  // Datapath: flush wins over either handshake; the final round holds its values
  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      state_d     = {DATA_W{1'b0}};
      round_d     = {CNT_W{1'b0}};
      out_valid_d = 1'b0;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          if (in_fire_s) begin
            state_d     = plain_in ^ key_round;
            round_d     = {CNT_W{1'b0}};
            out_valid_d = 1'b1;
          end else begin
            out_valid_d = out_valid_q;
          end
        end
        S_RUN: begin
          if (out_fire_s) begin
            if (!at_last_s) begin
              state_d = fb_state ^ key_round;
              round_d = round_q + CNT_W'(1);
            end else begin
              out_valid_d = 1'b0;
            end
          end else begin
            out_valid_d = out_valid_q;
          end
        end
        default: begin
          state_d     = {DATA_W{1'b0}};
          round_d     = {CNT_W{1'b0}};
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

`ifdef ADD_ROUND_PARITY_EN
  function automatic logic [PAR_W-1:0] byte_parity(input logic [DATA_W-1:0] v);
    logic [PAR_W-1:0] p;
    p = {PAR_W{1'b0}};
    for (int i = 0; i < PAR_W; i++) begin
      p[i] = ^v[8*i +: 8];
    end
    return p;
  endfunction

  logic [PAR_W-1:0] par_q;

  // Parity tracks state_d so it stays aligned with state_q
  always_ff @(posedge clk) begin
    if (!rst) begin
      par_q <= {PAR_W{1'b0}};
    end else begin
      par_q <= byte_parity(state_d);
    end
  end

  assign state_par_o = par_q;
`else
  assign state_par_o = {PAR_W{1'b0}};
`endif

endmodule

// File: tb/tb_add_round_seq.sv
// Randomized self-checking bench for add_round_seq (DATA_W=64, ROUNDS=25) with a
// transaction-level reference model of the keyed-round sequence.
module tb_add_round_seq;

  localparam int NR = 25;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] plain_in;
  logic [63:0] key_round;
  logic [63:0] fb_state;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] state_o;
  logic [4:0]  round_o;
  logic        last_o;
  logic [7:0]  state_par_o;

  int checks;
  int failures;

  add_round_seq #(.DATA_W(64), .ROUNDS(NR), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .plain_in(plain_in), .key_round(key_round), .fb_state(fb_state),
    .out_valid(out_valid), .out_ready(out_ready),
    .state_o(state_o), .round_o(round_o), .last_o(last_o),
    .state_par_o(state_par_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [7:0] exp_par(input logic [63:0] v);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = ^v[8*i +: 8];
`ifdef ADD_ROUND_PARITY_EN
    return p;
`else
    return 8'h00;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; plain_in = rnd64(); key_round = rnd64();
    step(); step();
    checks += 5;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
    if (state_o !== 64'h0) begin failures++; $display("FAIL reset_state got=%0h exp=0", state_o); end
    if (round_o !== 5'd0) begin failures++; $display("FAIL reset_round got=%0d exp=0", round_o); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0h exp=0", in_ready); end
    if (state_par_o !== 8'h00) begin failures++; $display("FAIL reset_par got=%0h exp=0", state_par_o); end
    in_valid = 1'b0; rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%0h exp=1", in_ready); end
    step();
    checks += 2;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%0h exp=1", in_ready); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_valid got=%0h exp=0", out_valid); end
  endtask

  task automatic test_load();
    plain_in = 64'h0123456789ABCDEF; key_round = 64'hFFFFFFFFFFFFFFFF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks += 6;
    if (state_o !== 64'hFEDCBA9876543210) begin failures++; $display("FAIL load_state got=%0h exp=fedcba9876543210", state_o); end
    if (round_o !== 5'd0) begin failures++; $display("FAIL load_round got=%0d exp=0", round_o); end
    if (out_valid !== 1'b1) begin failures++; $display("FAIL load_valid got=%0h exp=1", out_valid); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL load_in_ready got=%0h exp=0", in_ready); end
    if (last_o !== 1'b0) begin failures++; $display("FAIL load_last got=%0h exp=0", last_o); end
    if (state_par_o !== exp_par(64'hFEDCBA9876543210)) begin failures++; $display("FAIL load_par got=%0h exp=%0h", state_par_o, exp_par(64'hFEDCBA9876543210)); end
    do_flush();
  endtask

  task automatic test_stall();
    logic [63:0] exp_s;
    exp_s = rnd64();
    plain_in = exp_s; key_round = 64'h0; in_valid = 1'b1;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; plain_in = rnd64(); fb_state = rnd64(); key_round = rnd64();
      step();
      checks += 3;
      if (state_o !== exp_s) begin failures++; $display("FAIL stall_state cyc=%0d got=%0h exp=%0h", i, state_o, exp_s); end
      if (round_o !== 5'd0) begin failures++; $display("FAIL stall_round cyc=%0d got=%0d exp=0", i, round_o); end
      if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid cyc=%0d got=%0h exp=1", i, out_valid); end
    end
    in_valid = 1'b0;
    do_flush();
  endtask

  task automatic test_random_rounds(input int iter);
    logic [63:0] exp_s;
    int          exp_r;
    bit          exp_v;
    int          hs;
    int          cyc;
    plain_in = rnd64(); key_round = rnd64(); in_valid = 1'b1;
    exp_s = plain_in ^ key_round; exp_r = 0; exp_v = 1'b1; hs = 0; cyc = 0;
    step();
    while (exp_v && cyc < 500) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = $urandom_range(0, 1);
      plain_in  = rnd64(); fb_state = rnd64(); key_round = rnd64();
      if (out_ready) begin
        hs++;
        if (exp_r < NR) begin
          exp_s = fb_state ^ key_round;
          exp_r++;
        end else begin
          exp_v = 1'b0;
        end
      end
      step();
      cyc++;
      checks += 6;
      if (state_o !== exp_s) begin failures++; $display("FAIL rnd%0d_state cyc=%0d got=%0h exp=%0h", iter, cyc, state_o, exp_s); end
      if (round_o !== 5'(exp_r)) begin failures++; $display("FAIL rnd%0d_round cyc=%0d got=%0d exp=%0d", iter, cyc, round_o, exp_r); end
      if (out_valid !== exp_v) begin failures++; $display("FAIL rnd%0d_valid cyc=%0d got=%0h exp=%0h", iter, cyc, out_valid, exp_v); end
      if (last_o !== (exp_v && exp_r == NR)) begin failures++; $display("FAIL rnd%0d_last cyc=%0d got=%0h exp=%0h", iter, cyc, last_o, (exp_v && exp_r == NR)); end
      if (in_ready !== !exp_v) begin failures++; $display("FAIL rnd%0d_ready cyc=%0d got=%0h exp=%0h", iter, cyc, in_ready, !exp_v); end
      if (state_par_o !== exp_par(exp_s)) begin failures++; $display("FAIL rnd%0d_par cyc=%0d got=%0h exp=%0h", iter, cyc, state_par_o, exp_par(exp_s)); end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (hs !== NR + 1 || exp_v) begin failures++; $display("FAIL rnd%0d_handshakes got=%0d exp=%0d", iter, hs, NR + 1); end
  endtask

  task automatic test_toggle_back_to_back();
    logic [63:0] exp_s;
    logic [63:0] p;
    int          hs;
    p = rnd64();
    plain_in = p; key_round = 64'h1; in_valid = 1'b1;
    exp_s = p ^ 64'h1; hs = 0;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int r = 0; r <= NR; r++) begin
      checks += 3;
      if (round_o !== 5'(r)) begin failures++; $display("FAIL tog_round r=%0d got=%0d", r, round_o); end
      if (state_o !== exp_s) begin failures++; $display("FAIL tog_state r=%0d got=%0h exp=%0h", r, state_o, exp_s); end
      if (last_o !== (r == NR)) begin failures++; $display("FAIL tog_last r=%0d got=%0h exp=%0h", r, last_o, (r == NR)); end
      fb_state = state_o;
      hs++;
      if (r < NR) exp_s = exp_s ^ 64'h1;
      step();
    end
    checks += 4;
    if (hs !== NR + 1) begin failures++; $display("FAIL tog_handshakes got=%0d exp=%0d", hs, NR + 1); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL tog_done_ready got=%0h exp=1", in_ready); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL tog_done_valid got=%0h exp=0", out_valid); end
    if (round_o !== 5'd25 || state_o !== exp_s) begin failures++; $display("FAIL tog_hold got_r=%0d got_s=%0h exp_s=%0h", round_o, state_o, exp_s); end
    plain_in = rnd64(); key_round = rnd64(); in_valid = 1'b1; out_ready = 1'b0;
    exp_s = plain_in ^ key_round;
    step();
    in_valid = 1'b0;
    checks += 2;
    if (state_o !== exp_s) begin failures++; $display("FAIL b2b_state got=%0h exp=%0h", state_o, exp_s); end
    if (round_o !== 5'd0 || out_valid !== 1'b1) begin failures++; $display("FAIL b2b_round_valid got_r=%0d got_v=%0h", round_o, out_valid); end
    do_flush();
  endtask

  task automatic test_flush();
    plain_in = rnd64(); key_round = rnd64(); in_valid = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      fb_state = rnd64(); key_round = rnd64();
      step();
    end
    checks++;
    if (round_o !== 5'd10) begin failures++; $display("FAIL flush_setup_round got=%0d exp=10", round_o); end
    flush = 1'b1; out_ready = 1'b1; fb_state = rnd64(); key_round = rnd64();
    step();
    checks += 5;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0h exp=0", out_valid); end
    if (round_o !== 5'd0) begin failures++; $display("FAIL flush_round got=%0d exp=0", round_o); end
    if (state_o !== 64'h0) begin failures++; $display("FAIL flush_state got=%0h exp=0", state_o); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%0h exp=1", in_ready); end
    if (state_par_o !== 8'h00) begin failures++; $display("FAIL flush_par got=%0h exp=0", state_par_o); end
    flush = 1'b1; in_valid = 1'b1; plain_in = rnd64() | 64'h1; key_round = 64'h0;
    step();
    checks += 2;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_idle_valid got=%0h exp=0", out_valid); end
    if (state_o !== 64'h0) begin failures++; $display("FAIL flush_idle_state got=%0h exp=0", state_o); end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_parity();
    plain_in = 64'h0100000000000003; key_round = 64'h0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
`ifdef ADD_ROUND_PARITY_EN
    if (state_par_o !== 8'h80) begin failures++; $display("FAIL parity got=%0h exp=80", state_par_o); end
`else
    if (state_par_o !== 8'h00) begin failures++; $display("FAIL parity got=%0h exp=00", state_par_o); end
`endif
    do_flush();
  endtask

  task automatic test_reset_mid();
    plain_in = rnd64(); key_round = rnd64(); in_valid = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fb_state = rnd64(); step();
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks += 3;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid cyc=%0d got=%0h exp=0", i, out_valid); end
      if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready cyc=%0d got=%0h exp=1", i, in_ready); end
      if (round_o !== 5'd0) begin failures++; $display("FAIL rstmid_round cyc=%0d got=%0d exp=0", i, round_o); end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    plain_in = 64'h0; key_round = 64'h0; fb_state = 64'h0;
    test_reset();
    test_load();
    test_stall();
    for (int k = 0; k < 4; k++) test_random_rounds(k);
    test_toggle_back_to_back();
    test_flush();
    test_parity();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
